// File: rtl/truth_table_sweeper_if.sv
// Handshake/stimulus bundle between the sweeper and its cell-under-test harness.
interface truth_table_sweeper_if;
   logic       start;
   logic       abort;
   logic       f;
   logic       a;
   logic       b;
   logic       c;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] truth_table;
   logic [3:0] mismatch_cnt;

   // Controller/harness side: issues commands, models the cell output.
   modport master (
      output start, abort, f,
      input  a, b, c, busy, done, pass, truth_table, mismatch_cnt
   );

   // Sweeper side.
   modport slave (
      input  start, abort, f,
      output a, b, c, busy, done, pass, truth_table, mismatch_cnt
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input cell through all 8 input vectors, captures f after a settle
// delay into a truth table, and grades the table against a golden value.
module truth_table_sweeper #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter logic [7:0]  EXPECTED      = 8'hE8
) (
   input logic                   clk,
   input logic                   rst_n,
   truth_table_sweeper_if.slave  bus
);

   localparam logic [3:0] LP_LAST_CNT = 4'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LP_EXPECTED = EXPECTED;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t     r_state, w_state;
   logic [2:0] r_idx,   w_idx;
   logic [3:0] r_cnt,   w_cnt;
   logic       r_busy,  w_busy;
   logic       r_done,  w_done;
   logic       r_pass,  w_pass;
   logic [7:0] r_table, w_table;
   logic [3:0] r_mis,   w_mis;

   // State and all output registers; every output comes straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_table <= '0;
         r_mis   <= '0;
      end else begin
         r_state <= w_state;
         r_idx   <= w_idx;
         r_cnt   <= w_cnt;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_table <= w_table;
         r_mis   <= w_mis;
      end
   end

   // Next-state and next-register values; abort takes priority over capture.
   always_comb begin
      w_state = r_state;
      w_idx   = r_idx;
      w_cnt   = r_cnt;
      w_done  = 1'b0;
      w_pass  = r_pass;
      w_table = r_table;
      w_mis   = r_mis;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_table = '0;
               w_mis   = '0;
               w_pass  = 1'b0;
               w_idx   = '0;
               w_cnt   = '0;
               w_state = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (bus.abort) begin
               w_idx   = '0;
               w_pass  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_cnt = r_cnt + 4'd1;
               if (r_cnt == LP_LAST_CNT) begin
                  w_state = S_SAMPLE;
               end
            end
         end
         S_SAMPLE: begin
            if (bus.abort) begin
               w_idx   = '0;
               w_pass  = 1'b0;
               w_state = S_IDLE;
            end else begin
               w_table[r_idx] = bus.f;
               if ((bus.f != LP_EXPECTED[r_idx]) && (r_mis != 4'd8)) begin
                  w_mis = r_mis + 4'd1;
               end
               if (r_idx == 3'd7) begin
                  // Grade on the table including this final capture so pass
                  // is valid in the same cycle as done.
                  w_pass  = (w_table == LP_EXPECTED);
                  w_done  = 1'b1;
                  w_state = S_DONE;
               end else begin
                  w_idx   = r_idx + 3'd1;
                  w_cnt   = '0;
                  w_state = S_SETTLE;
               end
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
      w_busy = (w_state == S_SETTLE) || (w_state == S_SAMPLE);
   end

   assign bus.a            = r_idx[2];
   assign bus.b            = r_idx[1];
   assign bus.c            = r_idx[0];
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   assign bus.pass         = r_pass;
   assign bus.truth_table  = r_table;
   assign bus.mismatch_cnt = r_mis;

endmodule
